// File: rtl/cci_mpf_prim_drain_ctrl_if.sv
// Drain controller handshake bundle: drain request/ack, tracker status,
// fence handshake and the request-path block outputs.
interface cci_mpf_prim_drain_ctrl_if;
  logic drain_req;
  logic drain_fence_en;
  logic c0_not_empty;
  logic c1_not_empty;
  logic c1_tx_almfull;
  logic fence_sent;
  logic c0_block;
  logic c1_block;
  logic fence_req;
  logic drain_busy;
  logic drain_ack;
  logic drain_timeout;

  // Shim / requester side
  modport master (
    output drain_req, drain_fence_en, c0_not_empty, c1_not_empty,
           c1_tx_almfull, fence_sent,
    input  c0_block, c1_block, fence_req, drain_busy, drain_ack, drain_timeout
  );

  // Drain controller side
  modport slave (
    input  drain_req, drain_fence_en, c0_not_empty, c1_not_empty,
           c1_tx_almfull, fence_sent,
    output c0_block, c1_block, fence_req, drain_busy, drain_ack, drain_timeout
  );
endinterface

// File: rtl/cci_mpf_prim_drain_ctrl.sv
// Quiesce sequencer for a CCI request pipeline. Blocks new c0/c1 requests,
// optionally issues a single write fence, then waits for the active-request
// tracker to report both channels empty for SETTLE_CYCLES consecutive cycles
// before acknowledging. A sticky flag reports a drain that takes too long.
module cci_mpf_prim_drain_ctrl #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                            clk,
  input  logic                            reset,
  cci_mpf_prim_drain_ctrl_if.slave        drain
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BLOCK = 3'd1,
    ST_FENCE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_r, next_state_s;
  logic          fence_en_r, fence_en_s;
  logic [7:0]    settle_cnt_r, settle_cnt_s;
  logic [TW-1:0] timeout_cnt_r, timeout_cnt_s;
  logic          timeout_r, timeout_s;
  logic          block_r, busy_r, ack_r, fence_phase_r;
  logic [TW-1:0] timeout_inc_s;

  // Saturating increment of the timeout counter; frozen when timeout is disabled.
  always_comb begin
    timeout_inc_s = timeout_cnt_r;
    if (TIMEOUT_EN && (timeout_cnt_r != TIMEOUT_MAX)) begin
      timeout_inc_s = timeout_cnt_r + TW'(1);
    end else begin
      timeout_inc_s = timeout_cnt_r;
    end
  end

  // Next-state, settle and timeout counter logic.
  always_comb begin
    next_state_s  = state_r;
    fence_en_s    = fence_en_r;
    settle_cnt_s  = settle_cnt_r;
    timeout_cnt_s = timeout_cnt_r;
    timeout_s     = timeout_r;

    case (state_r)
      ST_IDLE: begin
        if (drain.drain_req) begin
          fence_en_s    = drain.drain_fence_en;
          timeout_cnt_s = '0;
          next_state_s  = ST_BLOCK;
        end else begin
          next_state_s  = ST_IDLE;
        end
      end

      ST_BLOCK: begin
        if (!drain.drain_req) begin
          next_state_s = ST_IDLE;
        end else if (fence_en_r) begin
          next_state_s = ST_FENCE;
        end else begin
          settle_cnt_s = 8'd0;
          next_state_s = ST_WAIT;
        end
      end

      // A started fence is always completed, even if the drain is withdrawn.
      ST_FENCE: begin
        timeout_cnt_s = timeout_inc_s;
        if (drain.fence_sent) begin
          if (drain.drain_req) begin
            settle_cnt_s = 8'd0;
            next_state_s = ST_WAIT;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_FENCE;
        end
      end

      // Withdrawal of the drain wins over completion.
      ST_WAIT: begin
        timeout_cnt_s = timeout_inc_s;
        if (!drain.drain_req) begin
          next_state_s = ST_IDLE;
        end else if (drain.c0_not_empty || drain.c1_not_empty) begin
          settle_cnt_s = 8'd0;
          next_state_s = ST_WAIT;
        end else if (settle_cnt_r == SETTLE_LAST) begin
          next_state_s = ST_DONE;
        end else begin
          settle_cnt_s = settle_cnt_r + 8'd1;
          next_state_s = ST_WAIT;
        end
      end

      ST_DONE: begin
        if (!drain.drain_req) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end

      default: begin
        next_state_s = ST_IDLE;
      end
    endcase

    if (TIMEOUT_EN && (timeout_cnt_s == TIMEOUT_MAX)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = timeout_r;
    end
  end

  // State, counters and registered output decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      fence_en_r    <= 1'b0;
      settle_cnt_r  <= 8'd0;
      timeout_cnt_r <= '0;
      timeout_r     <= 1'b0;
      block_r       <= 1'b0;
      busy_r        <= 1'b0;
      ack_r         <= 1'b0;
      fence_phase_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      fence_en_r    <= fence_en_s;
      settle_cnt_r  <= settle_cnt_s;
      timeout_cnt_r <= timeout_cnt_s;
      timeout_r     <= timeout_s;
      block_r       <= (next_state_s != ST_IDLE);
      busy_r        <= (next_state_s != ST_IDLE);
      ack_r         <= (next_state_s == ST_DONE);
      fence_phase_r <= (next_state_s == ST_FENCE);
    end
  end

  // The fence request is held off while c1 Tx is almost full; this is the
  // only combinational input-to-output path.
  assign drain.fence_req     = fence_phase_r & ~drain.c1_tx_almfull;
  assign drain.c0_block      = block_r;
  assign drain.c1_block      = block_r;
  assign drain.drain_busy    = busy_r;
  assign drain.drain_ack     = ack_r;
  assign drain.drain_timeout = timeout_r;

endmodule

// File: tb/tb_cci_mpf_prim_drain_ctrl.sv
// Scoreboard bench for the drain controller: directed scenarios followed by
// randomized traffic, checked every cycle against a behavioural model.
module tb_cci_mpf_prim_drain_ctrl;

  localparam int S_CYC  = 4;
  localparam int TO_CYC = 16;

  logic clk;
  logic reset;

  cci_mpf_prim_drain_ctrl_if drain();

  cci_mpf_prim_drain_ctrl #(
    .SETTLE_CYCLES  (S_CYC),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .drain (drain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       check;
    int       cyc;
    bit [5:0] outs;  // {c0_block, c1_block, fence_req, drain_busy, drain_ack, drain_timeout}
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  // Behavioural model: phase of the drain session, history of empty cycles
  // seen in the current wait, and elapsed fence+wait cycles since the drain began.
  typedef enum {P_IDLE, P_BLOCK, P_FENCE, P_WAIT, P_DONE} phase_t;
  phase_t m_phase = P_IDLE;
  bit     m_known = 0;
  bit     m_fence = 0;
  bit     m_to    = 0;
  int     m_elapsed = 0;
  bit     m_hist[$];

  function automatic bit settled();
    if (m_hist.size() < S_CYC) return 0;
    foreach (m_hist[i]) if (!m_hist[i]) return 0;
    return 1;
  endfunction

  task automatic model_update(input bit rq, fen, c0, c1, fs, rst);
    if (rst) begin
      m_phase = P_IDLE; m_to = 0; m_elapsed = 0; m_known = 1; m_hist.delete();
      return;
    end
    case (m_phase)
      P_IDLE: if (rq) begin m_fence = fen; m_elapsed = 0; m_phase = P_BLOCK; end
      P_BLOCK: begin
        if (!rq) m_phase = P_IDLE;
        else if (m_fence) m_phase = P_FENCE;
        else begin m_phase = P_WAIT; m_hist.delete(); end
      end
      P_FENCE: begin
        m_elapsed++;
        if (fs) begin
          if (rq) begin m_phase = P_WAIT; m_hist.delete(); end
          else m_phase = P_IDLE;
        end
      end
      P_WAIT: begin
        m_elapsed++;
        if (!rq) m_phase = P_IDLE;
        else begin
          m_hist.push_back(!(c0 || c1));
          if (m_hist.size() > S_CYC) void'(m_hist.pop_front());
          if (settled()) m_phase = P_DONE;
        end
      end
      P_DONE: if (!rq) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
    if (TO_CYC != 0 && m_elapsed >= TO_CYC) m_to = 1;
  endtask

  // One clock cycle of stimulus: drive, predict, advance the model.
  task automatic step(input bit rq, fen, c0, c1, alm, fs, rst);
    exp_t e;
    bit   busy;
    @(posedge clk);
    #1;
    cycle++;
    reset                = rst;
    drain.drain_req      = rq;
    drain.drain_fence_en = fen;
    drain.c0_not_empty   = c0;
    drain.c1_not_empty   = c1;
    drain.c1_tx_almfull  = alm;
    drain.fence_sent     = fs;
    busy    = (m_phase != P_IDLE);
    e.check = m_known;
    e.cyc   = cycle;
    e.outs  = {busy, busy, (m_phase == P_FENCE) && !alm, busy, (m_phase == P_DONE), m_to};
    sb.push_back(e);
    model_update(rq, fen, c0, c1, fs, rst);
  endtask

  task automatic run(input int n, input bit rq, fen, c0, c1, alm, fs);
    for (int k = 0; k < n; k++) step(rq, fen, c0, c1, alm, fs, 1'b0);
  endtask

  // Monitor: compare the DUT outputs against the oldest prediction.
  always @(negedge clk) begin
    exp_t     e;
    bit [5:0] got;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.check) begin
        got = {drain.c0_block, drain.c1_block, drain.fence_req,
               drain.drain_busy, drain.drain_ack, drain.drain_timeout};
        n_checks++;
        if (got !== e.outs) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %b required %b (blk0 blk1 fence busy ack tmo)",
                   e.cyc, got, e.outs);
        end
      end
    end
  end

  initial begin
    bit rq, fen, c0, c1, alm, fs, rst;
    reset = 1'b1;
    drain.drain_req = 1'b0; drain.drain_fence_en = 1'b0;
    drain.c0_not_empty = 1'b0; drain.c1_not_empty = 1'b0;
    drain.c1_tx_almfull = 1'b0; drain.fence_sent = 1'b0;

    // Reset
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    run(2, 0, 0, 0, 0, 0, 0);

    // Basic no-fence drain, then release
    run(8, 1, 0, 0, 0, 0, 0);
    run(3, 0, 0, 0, 0, 0, 0);

    // Fence drain: almfull for 3 FENCE cycles, fence_sent 2 cycles after it clears
    run(2, 1, 1, 0, 1, 0, 0);
    run(3, 1, 1, 0, 1, 1, 0);
    run(2, 1, 1, 0, 1, 0, 0);
    run(1, 1, 1, 0, 1, 0, 1);
    run(10, 1, 1, 0, 1, 0, 0);
    run(7, 1, 1, 0, 0, 0, 0);
    run(2, 0, 0, 0, 0, 0, 0);

    // Settle restart
    step(0, 0, 0, 0, 0, 0, 1);
    run(4, 1, 0, 1, 0, 0, 0);
    run(3, 1, 0, 0, 0, 0, 0);
    run(1, 1, 0, 1, 0, 0, 0);
    run(6, 1, 0, 0, 0, 0, 0);
    run(2, 0, 0, 0, 0, 0, 0);

    // Abort in WAIT, then abort in FENCE (fence still completes)
    run(5, 1, 0, 1, 0, 0, 0);
    run(2, 0, 0, 0, 0, 0, 0);
    run(3, 1, 1, 0, 0, 0, 0);
    run(3, 0, 0, 0, 0, 0, 0);
    run(1, 0, 0, 0, 0, 0, 1);
    run(2, 0, 0, 0, 0, 0, 0);

    // Timeout with c0 stuck busy, then release
    step(0, 0, 0, 0, 0, 0, 1);
    run(25, 1, 0, 1, 0, 0, 0);
    run(6, 1, 0, 0, 0, 0, 0);
    run(2, 0, 0, 0, 0, 0, 0);

    // Reset mid-fence with drain_req held
    run(4, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1);
    run(4, 1, 0, 0, 0, 0, 0);
    run(2, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    rq = 0; fen = 0; c0 = 0; c1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) rq = ~rq;
      if ($urandom_range(5, 0) == 0)  c0 = ~c0;
      if ($urandom_range(5, 0) == 0)  c1 = ~c1;
      fen = 1'($urandom_range(1, 0));
      alm = ($urandom_range(2, 0) == 0);
      fs  = ($urandom_range(4, 0) == 0);
      rst = ($urandom_range(299, 0) == 0);
      step(rq, fen, c0, c1, alm, fs, rst);
    end

    // Let the monitor consume remaining predictions (bounded)
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cci_mpf_prim_drain_ctrl.md
Name: cci_mpf_prim_drain_ctrl

Overview:
- Quiesce sequencer for a CCI request pipeline. On a drain request it blocks new read/write requests, optionally issues one write fence, and waits until the active-request tracker reports both channels empty for a settle window. It then acknowledges.
- Sits beside the active-request tracker in an MPF shim and gates that shim's c0Tx/c1Tx request paths.
- Used before address-translation changes, soft reset and performance-counter snapshots.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles both channels must read empty before ack; covers the tracker's counter pipeline latency; legal range 1..255.
- TIMEOUT_CYCLES, 65536: wait cycles before the timeout flag is raised; 0 disables timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- drain_req  in  1  level; drain requested while high
- drain_fence_en  in  1  sampled in IDLE when drain starts; 1 = issue write fence
- c0_not_empty  in  1  tracker: reads outstanding
- c1_not_empty  in  1  tracker: writes/fences outstanding
- c1_tx_almfull  in  1  c1 Tx almost-full
- fence_sent  in  1  pulse: requested fence accepted onto c1Tx
- c0_block  out  1  suppress new c0 read requests
- c1_block  out  1  suppress new c1 write requests; never blocks the controller's fence
- fence_req  out  1  request the shim to emit one write fence
- drain_busy  out  1  FSM not in IDLE
- drain_ack  out  1  drained; held while in DONE
- drain_timeout  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; all outputs 0; settle and timeout counters 0; drain_timeout cleared. Reset overrides any state, including mid-fence; an outstanding fence_req drops immediately.
- IDLE:
  - Outputs 0.
  - If drain_req = 1: latch drain_fence_en and go to BLOCK.
- BLOCK:
  - c0_block and c1_block go to 1, registered, in the first BLOCK cycle. They stay 1 in every non-IDLE state.
  - One cycle only. Next state is FENCE if the latched fence_en = 1, otherwise WAIT.
  - If drain_req = 0, go to IDLE instead.
- FENCE:
  - fence_req = ~c1_tx_almfull.
  - On fence_sent: fence_req drops the next cycle. Go to WAIT if drain_req = 1, otherwise IDLE.
  - A drop of drain_req is ignored until fence_sent arrives; no fence is abandoned.
  - A fence_sent seen in any other state is ignored.
- WAIT:
  - settle_cnt increments when c0_not_empty = 0 and c1_not_empty = 0. It clears to 0 on any cycle where either input is 1, and is cleared on entry to WAIT.
  - When settle_cnt reaches SETTLE_CYCLES, go to DONE. Minimum WAIT residency is SETTLE_CYCLES cycles.
  - If drain_req = 0, go to IDLE. This has priority over the transition to DONE.
- DONE:
  - drain_ack = 1; blocks stay 1.
  - When drain_req = 0, go to IDLE. drain_ack and the blocks drop in that IDLE cycle.
  - Not-empty inputs are ignored in DONE.
- Timeout:
  - Counter clears on entry to BLOCK and increments in FENCE and WAIT. It saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES (nonzero), drain_timeout is set. It stays set until reset.
  - The FSM keeps waiting; timeout does not force ack.
- drain_busy = (state != IDLE).
- Re-entry: DONE -> IDLE -> BLOCK takes at least one IDLE cycle even if drain_req pulses low for only one cycle.
- All outputs are registered (state-decoded from registers); there are no combinational input-to-output paths except fence_req's dependence on c1_tx_almfull. That path is intentional and is the only exception.

Test Plan:
- Basic no-fence drain: tracker already empty, drain_req = 1 at cycle 0, fence_en = 0, SETTLE_CYCLES = 4 -> blocks = 1 from cycle 1, drain_ack = 1 at cycle 6; drain_req = 0 -> ack and blocks drop the next cycle.
- Fence drain:
  - Stimulus: fence_en = 1, c1_tx_almfull = 1 for 3 cycles after FENCE entry, fence_sent 2 cycles after almfull clears; c1_not_empty held 1 for 10 cycles after fence_sent.
  - Expected: fence_req = 0 while almfull; exactly one fence_sent consumed; ack exactly 4 cycles after c1_not_empty falls.
- Settle restart: in WAIT, c0_not_empty goes 0 for 3 cycles, pulses 1 for 1 cycle, then 0 -> no ack until 4 consecutive empty cycles after the pulse.
- Abort: drain_req drops in WAIT -> IDLE next cycle, blocks = 0, no ack. drain_req drops in FENCE before fence_sent -> fence_req held until fence_sent, then IDLE.
- Timeout: TIMEOUT_CYCLES = 16, c0_not_empty stuck at 1 -> drain_timeout = 1 at 16 cycles after BLOCK exit, FSM remains in WAIT. Release c0_not_empty -> ack after 4 cycles, timeout stays 1.
- Reset mid-operation: reset asserted in FENCE with fence_req = 1 -> next cycle all outputs 0, drain_timeout = 0. With drain_req still 1 after reset deasserts -> a new drain begins in BLOCK.
